// File: rtl/mac_shift_seq.sv
// Signed WxW radix-2 Booth shift-add multiplier with optional accumulation,
// round-half-up fixed-point rescale and saturation; one result every W+2 cycles.
module mac_shift_seq #(
  parameter int W     = 8,
  parameter int OUT_W = 8,
  parameter int FRAC  = 7,
  parameter int ACC_W = 2*W + 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    acc_en,
  input  logic                    clr_acc,
  input  logic signed [W-1:0]     a,
  input  logic signed [W-1:0]     b,
  output logic                    busy,
  output logic                    done,
  output logic signed [2*W-1:0]   product,
  output logic signed [ACC_W-1:0] acc_out,
  output logic signed [OUT_W-1:0] result,
  output logic                    ovf
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_CALC   = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  localparam int CNT_W = $clog2(W + 1);
  localparam int RSH   = (FRAC > 0) ? FRAC - 1 : 0;

  localparam logic signed [ACC_W:0] ONE_K   = {{ACC_W{1'b0}}, 1'b1};
  localparam logic signed [ACC_W:0] RND_K   = (FRAC > 0) ? (ONE_K <<< RSH) : '0;
  localparam logic signed [ACC_W:0] SAT_MAX = (ONE_K <<< (OUT_W - 1)) - ONE_K;
  localparam logic signed [ACC_W:0] SAT_MIN = ~SAT_MAX;

  // Rounding add is done one bit wider so a positive accumulator near full scale cannot wrap.
  function automatic logic signed [ACC_W:0] f_round_shift(input logic signed [ACC_W-1:0] x);
    logic signed [ACC_W:0] xe;
    xe = (ACC_W + 1)'(x);
    return (xe + RND_K) >>> FRAC;
  endfunction

  // Returns {clamped, value}.
  function automatic logic [OUT_W:0] f_saturate(input logic signed [ACC_W:0] t);
    if (t > SAT_MAX)      return {1'b1, SAT_MAX[OUT_W-1:0]};
    else if (t < SAT_MIN) return {1'b1, SAT_MIN[OUT_W-1:0]};
    else                  return {1'b0, t[OUT_W-1:0]};
  endfunction

  logic [1:0]              r_state;
  logic [CNT_W-1:0]        r_cnt;
  logic                    r_done;
  logic                    r_acc_en;
  logic signed [2*W-1:0]   r_product;
  logic signed [ACC_W-1:0] r_acc;
  logic signed [OUT_W-1:0] r_result;
  logic                    r_ovf;

  // Booth working registers: {r_pa, r_pq, r_q1} is the shifting partial product.
  logic signed [W-1:0]     r_m;
  logic signed [W:0]       r_pa;
  logic [W-1:0]            r_pq;
  logic                    r_q1;

  logic signed [W:0]       w_m_ext;
  logic signed [W:0]       w_sum;
  logic signed [2*W-1:0]   w_prod;
  logic signed [ACC_W-1:0] w_acc_base;
  logic signed [ACC_W-1:0] w_acc_new;
  logic signed [ACC_W:0]   w_scaled;
  logic [OUT_W:0]          w_sat;

  assign w_m_ext = {r_m[W-1], r_m};

  always_comb begin
    w_sum = r_pa;
    case ({r_pq[0], r_q1})
      2'b01:   w_sum = r_pa + w_m_ext;
      2'b10:   w_sum = r_pa - w_m_ext;
      default: w_sum = r_pa;
    endcase
  end

  // The extra top bit of r_pa absorbs the -2^(W-1) * -2^(W-1) corner; the low 2W bits are exact.
  assign w_prod     = {r_pa[W-1:0], r_pq};
  assign w_acc_base = r_acc_en ? r_acc : '0;
  assign w_acc_new  = w_acc_base + ACC_W'(w_prod);
  assign w_scaled   = f_round_shift(w_acc_new);
  assign w_sat      = f_saturate(w_scaled);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_done    <= 1'b0;
      r_acc_en  <= 1'b0;
      r_product <= '0;
      r_acc     <= '0;
      r_result  <= '0;
      r_ovf     <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (clr_acc) r_acc <= '0;
          if (start) begin
            r_state  <= S_CALC;
            r_cnt    <= '0;
            r_acc_en <= acc_en;
          end
        end
        S_CALC: begin
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_W'(W - 1)) r_state <= S_FINISH;
        end
        S_FINISH: begin
          r_product <= w_prod;
          r_acc     <= w_acc_new;
          r_result  <= w_sat[OUT_W-1:0];
          r_ovf     <= w_sat[OUT_W];
          r_done    <= 1'b1;
          r_state   <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (r_state == S_IDLE && start) begin
      r_m  <= a;
      r_pa <= '0;
      r_pq <= b;
      r_q1 <= 1'b0;
    end else if (r_state == S_CALC) begin
      r_pa <= {w_sum[W], w_sum[W:1]};
      r_pq <= {w_sum[0], r_pq[W-1:1]};
      r_q1 <= r_pq[0];
    end
  end

  assign busy    = (r_state != S_IDLE);
  assign done    = r_done;
  assign product = r_product;
  assign acc_out = r_acc;
  assign result  = r_result;
  assign ovf     = r_ovf;

endmodule

// File: tb/tb_mac_shift_seq.sv
// Directed and randomized bench for mac_shift_seq against an arithmetic reference model.
module tb_mac_shift_seq;
  localparam int W     = 8;
  localparam int OUT_W = 8;
  localparam int FRAC  = 7;
  localparam int ACC_W = 2*W + 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             acc_en;
  logic             clr_acc;
  logic [W-1:0]     a;
  logic [W-1:0]     b;
  logic             busy;
  logic             done;
  logic [2*W-1:0]   product;
  logic [ACC_W-1:0] acc_out;
  logic [OUT_W-1:0] result;
  logic             ovf;

  int     n_assert = 0;
  int     n_fail   = 0;
  longint m_prod   = 0;
  longint m_acc    = 0;
  longint m_res    = 0;
  longint m_ovf    = 0;

  mac_shift_seq #(.W(W), .OUT_W(OUT_W), .FRAC(FRAC), .ACC_W(ACC_W)) dut (
    .clk(clk), .reset(reset), .start(start), .acc_en(acc_en), .clr_acc(clr_acc),
    .a(a), .b(b), .busy(busy), .done(done), .product(product),
    .acc_out(acc_out), .result(result), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: exact product, modular accumulate, floor((acc + half) / 2^FRAC), clamp.
  task automatic model_op(input int ia, input int ib, input bit en, input bit clr);
    longint x, t, md, lo, hi, rnd;
    if (clr) m_acc = 0;
    m_prod = longint'(ia) * longint'(ib);
    x  = (en ? m_acc : 0) + m_prod;
    md = longint'(1) << ACC_W;
    x  = x % md;
    if (x < 0) x += md;
    if (x >= md / 2) x -= md;
    m_acc = x;
    rnd = (FRAC > 0) ? (longint'(1) << (FRAC - 1)) : 0;
    t   = (x + rnd) >>> FRAC;
    hi  = (longint'(1) << (OUT_W - 1)) - 1;
    lo  = -(longint'(1) << (OUT_W - 1));
    m_ovf = 0;
    if (t > hi) begin t = hi; m_ovf = 1; end
    if (t < lo) begin t = lo; m_ovf = 1; end
    m_res = t;
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".product"}, $signed(product), m_prod);
    chk({tag, ".acc_out"}, $signed(acc_out), m_acc);
    chk({tag, ".result"},  $signed(result),  m_res);
    chk({tag, ".ovf"},     longint'(ovf),    m_ovf);
  endtask

  // Called #1 after the start edge; returns with the bench sitting in the done cycle.
  task automatic wait_done(input string tag, input int inj);
    int cyc;
    cyc = 0;
    while (done !== 1'b1 && cyc < W + 4) begin
      chk({tag, ".busy"}, longint'(busy), 1);
      if (inj > 0 && cyc == inj) begin
        start = 1'b1; a = 8'h11; b = 8'h22; clr_acc = 1'b1;
      end else if (inj > 0 && cyc == inj + 1) begin
        start = 1'b0; clr_acc = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    chk({tag, ".latency"}, cyc, W + 1);
    chk({tag, ".busy_at_done"}, longint'(busy), 0);
  endtask

  task automatic run_op(input string tag, input int ia, input int ib,
                        input bit en, input bit clr, input int inj);
    a = ia[W-1:0]; b = ib[W-1:0];
    acc_en = en; clr_acc = clr; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; clr_acc = 1'b0;
    model_op(ia, ib, en, clr);
    wait_done(tag, inj);
    check_outputs(tag);
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, longint'(done), 0);
    chk({tag, ".idle_after"}, longint'(busy), 0);
  endtask

  initial begin
    reset = 1'b0; start = 1'b0; acc_en = 1'b0; clr_acc = 1'b0; a = '0; b = '0;
    #12;
    chk("rst.busy", longint'(busy), 0);
    chk("rst.done", longint'(done), 0);
    check_outputs("rst");
    #10 reset = 1'b1;
    @(posedge clk); #1;

    run_op("t1", 127, 127, 1'b0, 1'b0, 0);
    chk("t1.product_lit", $signed(product), 16129);
    chk("t1.result_lit",  $signed(result),  126);

    run_op("t2a", -128, -128, 1'b0, 1'b0, 0);
    chk("t2a.product_lit", $signed(product), 16384);
    chk("t2a.ovf_lit",     longint'(ovf),    1);
    run_op("t2b", -127, -127, 1'b0, 1'b0, 0);

    run_op("t3a", -10, 11, 1'b0, 1'b0, 0);
    chk("t3a.result_lit", $signed(result), -1);
    run_op("t3b", -55, 33, 1'b0, 1'b0, 0);
    chk("t3b.result_lit", $signed(result), -14);

    run_op("t4a", 127, 127, 1'b1, 1'b1, 0);
    run_op("t4b", 127, 127, 1'b1, 1'b0, 0);
    chk("t4b.acc_lit", $signed(acc_out), 32258);
    run_op("t4c", 1, 1, 1'b0, 1'b0, 0);

    // Clear in IDLE zeroes only the accumulator.
    clr_acc = 1'b1;
    @(posedge clk); #1;
    clr_acc = 1'b0;
    m_acc = 0;
    check_outputs("clr");

    run_op("t5seed", 40, -3, 1'b0, 1'b0, 0);
    run_op("t5", 9, -7, 1'b1, 1'b0, 3);

    // start held high: second launch in the done cycle.
    a = 8'd5; b = 8'hF9; acc_en = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    model_op(5, -7, 1'b1, 1'b0);
    wait_done("hold1", 0);
    check_outputs("hold1");
    @(posedge clk); #1;
    start = 1'b0;
    chk("hold.relaunch_busy", longint'(busy), 1);
    model_op(5, -7, 1'b1, 1'b0);
    wait_done("hold2", -1);
    check_outputs("hold2");
    @(posedge clk); #1;

    for (int i = 0; i < 16; i++) begin
      int ra, rb;
      bit ren, rclr;
      ra   = int'($urandom_range(0, 255)) - 128;
      rb   = int'($urandom_range(0, 255)) - 128;
      ren  = 1'($urandom_range(0, 1));
      rclr = ($urandom_range(0, 3) == 0);
      run_op($sformatf("rnd%0d", i), ra, rb, ren, rclr, 0);
    end

    // Asynchronous abort in the middle of CALC.
    a = 8'd100; b = 8'd100; acc_en = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #3 reset = 1'b0;
    #1;
    chk("t6.busy", longint'(busy), 0);
    chk("t6.done", longint'(done), 0);
    m_acc = 0; m_prod = 0; m_res = 0; m_ovf = 0;
    check_outputs("t6");
    @(posedge clk); #1;
    reset = 1'b1;
    for (int i = 0; i < W + 3; i++) begin
      @(posedge clk); #1;
      chk("t6.no_done", longint'(done), 0);
    end
    run_op("t6b", 2, 3, 1'b0, 1'b0, 0);
    chk("t6b.product_lit", $signed(product), 6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
